// File: rtl/ir_capture_sequencer_pkg.sv
// Shared types, default constants and the saturating magnitude helper for the
// impulse-response capture sequencer.
package ir_capture_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StPulse  = 3'd2,
    StSkip   = 3'd3,
    StRecord = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } ir_cap_state_t;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned IR_LENGTH_DEF       = 3000;
  localparam int unsigned ADDR_W_DEF          = 12;
  localparam int unsigned QUIET_SAMPLES_DEF   = 2400;
  localparam int unsigned QUIET_THRESH_DEF    = 512;
  localparam int unsigned TIMEOUT_SAMPLES_DEF = 48000;
  localparam int unsigned PULSE_SAMPLES_DEF   = 4;
  localparam sample_t     PULSE_AMP_DEF       = 16'sh7FFF;

  // -32768 has no positive twin in 16 bits, so it clamps to 32767.
  function automatic logic [15:0] sat_abs(sample_t s);
    logic [15:0] r;
    if (s == 16'sh8000) begin
      r = 16'h7FFF;
    end else if (s[15]) begin
      r = $unsigned(-s);
    end else begin
      r = $unsigned(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_capture_sequencer_if.sv
// IR buffer write port: the sequencer drives it (master), the buffer consumes it (slave).
interface ir_capture_sequencer_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [ADDR_W-1:0]       ir_write_addr;
  ir_capture_pkg::sample_t ir_write_data;
  logic                    ir_write_enable;

  modport master (output ir_write_addr, output ir_write_data, output ir_write_enable);
  modport slave  (input ir_write_addr, input ir_write_data, input ir_write_enable);
endinterface

// File: rtl/ir_capture_sequencer_quiet_detector.sv
// Counts consecutive strobed samples whose magnitude is under QUIET_THRESH and
// flags the strobe on which the run reaches QUIET_SAMPLES.
module quiet_detector
  import ir_capture_pkg::*;
#(
  parameter int unsigned QUIET_SAMPLES = QUIET_SAMPLES_DEF,
  parameter int unsigned QUIET_THRESH  = QUIET_THRESH_DEF
) (
  input  logic    audio_clk,
  input  logic    rst_in_n,
  input  logic    clear,
  input  logic    strobe,
  input  sample_t sample,
  output logic    quiet_done
);

  localparam int unsigned CntW = $clog2(QUIET_SAMPLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            quiet;

  always_comb begin
    quiet      = sat_abs(sample) < 16'(QUIET_THRESH);
    cnt_d      = cnt_q;
    quiet_done = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (strobe) begin
      if (!quiet) begin
        cnt_d = '0;
      end else if (cnt_q < CntW'(QUIET_SAMPLES)) begin
        cnt_d      = cnt_q + 1'b1;
        quiet_done = (cnt_q == CntW'(QUIET_SAMPLES - 1));
      end
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_capture_sequencer.sv
// Impulse-response capture controller: quiet wait, test pulse, acoustic-delay skip,
// then IR_LENGTH buffer writes. Optional peak tracking under IR_CAPTURE_PEAK_EN.
module ir_capture_sequencer
  import ir_capture_pkg::*;
#(
  parameter int unsigned IR_LENGTH       = IR_LENGTH_DEF,
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned QUIET_SAMPLES   = QUIET_SAMPLES_DEF,
  parameter int unsigned QUIET_THRESH    = QUIET_THRESH_DEF,
  parameter int unsigned TIMEOUT_SAMPLES = TIMEOUT_SAMPLES_DEF,
  parameter int unsigned PULSE_SAMPLES   = PULSE_SAMPLES_DEF,
  parameter sample_t     PULSE_AMP       = PULSE_AMP_DEF
) (
  input  logic                          audio_clk,
  input  logic                          rst_in_n,
  input  logic                          audio_trigger,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    delay_length,
  input  sample_t                       audio_in,
  output sample_t                       impulse_out,
  ir_capture_sequencer_if.master        ir_wr,
  output logic                          impulse_recorded,
  output logic                          busy,
  output logic                          error,
  output logic [2:0]                    state_out
`ifdef IR_CAPTURE_PEAK_EN
  ,
  output logic [15:0]                   peak_mag,
  output logic [ADDR_W-1:0]             peak_addr
`endif
);

  localparam int unsigned ToW = $clog2(TIMEOUT_SAMPLES + 1);

  ir_cap_state_t     state_q, state_d;
  logic              start_q;
  logic              start_rise;
  logic              arm_entry;
  logic              quiet_done;
  logic [ToW-1:0]    timeout_q, timeout_d;
  logic [8:0]        skip_q, skip_d;
  logic [7:0]        delay_q, delay_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  sample_t           imp_q, imp_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  sample_t           wr_data_q, wr_data_d;
  logic              rec_q, rec_d;
`ifdef IR_CAPTURE_PEAK_EN
  logic [15:0]       peak_mag_q, peak_mag_d;
  logic [ADDR_W-1:0] peak_addr_q, peak_addr_d;
`endif

  assign start_rise = start & ~start_q;

  quiet_detector #(
    .QUIET_SAMPLES(QUIET_SAMPLES),
    .QUIET_THRESH (QUIET_THRESH)
  ) u_quiet (
    .audio_clk (audio_clk),
    .rst_in_n  (rst_in_n),
    .clear     (arm_entry),
    .strobe    (audio_trigger && (state_q == StArm)),
    .sample    (audio_in),
    .quiet_done(quiet_done)
  );

  always_comb begin
    state_d   = state_q;
    arm_entry = 1'b0;
    timeout_d = timeout_q;
    skip_d    = skip_q;
    delay_d   = delay_q;
    idx_d     = idx_q;
    imp_d     = imp_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rec_d     = rec_q;
`ifdef IR_CAPTURE_PEAK_EN
    peak_mag_d  = peak_mag_q;
    peak_addr_d = peak_addr_q;
`endif

    // The pulse drive is refreshed on every strobe, so it drops on the first strobe
    // outside PULSE whichever state follows.
    if (audio_trigger) begin
      imp_d = (state_q == StPulse) ? PULSE_AMP : '0;
    end

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_rise) begin
          arm_entry = 1'b1;
        end
      end
      StArm: begin
        if (audio_trigger) begin
          timeout_d = timeout_q + 1'b1;
          if (quiet_done) begin
            state_d = StPulse;
            skip_d  = '0;
            delay_d = delay_length;
            idx_d   = '0;
          end else if (timeout_q == ToW'(TIMEOUT_SAMPLES - 1)) begin
            state_d = StError;
          end
        end
      end
      StPulse: begin
        if (audio_trigger) begin
          skip_d = skip_q + 1'b1;
          if (skip_q == 9'(PULSE_SAMPLES - 1)) begin
            state_d = ({1'b0, delay_q} <= 9'(PULSE_SAMPLES)) ? StRecord : StSkip;
          end
        end
      end
      StSkip: begin
        if (audio_trigger) begin
          skip_d = skip_q + 1'b1;
          if ((skip_q + 9'd1) == {1'b0, delay_q}) begin
            state_d = StRecord;
          end
        end
      end
      StRecord: begin
        if (audio_trigger) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = audio_in;
          idx_d     = idx_q + 1'b1;
`ifdef IR_CAPTURE_PEAK_EN
          if (sat_abs(audio_in) > peak_mag_q) begin
            peak_mag_d  = sat_abs(audio_in);
            peak_addr_d = idx_q;
          end
`endif
          if (idx_q == ADDR_W'(IR_LENGTH - 1)) begin
            state_d = StDone;
            rec_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (arm_entry) begin
      state_d   = StArm;
      rec_d     = 1'b0;
      timeout_d = '0;
`ifdef IR_CAPTURE_PEAK_EN
      peak_mag_d  = '0;
      peak_addr_d = '0;
`endif
    end

    if (abort) begin
      state_d   = StIdle;
      arm_entry = 1'b0;
      imp_d     = '0;
      wr_en_d   = 1'b0;
      rec_d     = 1'b0;
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      timeout_q <= '0;
      skip_q    <= '0;
      delay_q   <= '0;
      idx_q     <= '0;
      imp_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      timeout_q <= timeout_d;
      skip_q    <= skip_d;
      delay_q   <= delay_d;
      idx_q     <= idx_d;
      imp_q     <= imp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rec_q     <= rec_d;
    end
  end

`ifdef IR_CAPTURE_PEAK_EN
  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      peak_mag_q  <= '0;
      peak_addr_q <= '0;
    end else begin
      peak_mag_q  <= peak_mag_d;
      peak_addr_q <= peak_addr_d;
    end
  end

  assign peak_mag  = peak_mag_q;
  assign peak_addr = peak_addr_q;
`endif

  assign impulse_out           = imp_q;
  assign ir_wr.ir_write_addr   = wr_addr_q;
  assign ir_wr.ir_write_data   = wr_data_q;
  assign ir_wr.ir_write_enable = wr_en_q;
  assign impulse_recorded      = rec_q;
  assign busy                  = (state_q == StArm) || (state_q == StPulse) ||
                                 (state_q == StSkip) || (state_q == StRecord);
  assign error                 = (state_q == StError);
  assign state_out             = state_q;

endmodule

// File: tb/tb_ir_capture_sequencer.sv
// Directed bench for ir_capture_sequencer with scaled-down sample counts; peak checks
// are active only when IR_CAPTURE_PEAK_EN is defined.
module tb_ir_capture_sequencer;
  import ir_capture_pkg::*;

  localparam int unsigned IRL = 12;
  localparam int unsigned AW  = 4;
  localparam int unsigned QS  = 6;
  localparam int unsigned QT  = 512;
  localparam int unsigned TO  = 30;
  localparam int unsigned PS  = 4;

  logic       audio_clk = 1'b0;
  logic       rst_in_n;
  logic       audio_trigger;
  logic       start;
  logic       abort;
  logic [7:0] delay_length;
  sample_t    audio_in;
  sample_t    impulse_out;
  logic       impulse_recorded;
  logic       busy;
  logic       error;
  logic [2:0] state_out;
`ifdef IR_CAPTURE_PEAK_EN
  logic [15:0]   peak_mag;
  logic [AW-1:0] peak_addr;
`endif

  ir_capture_sequencer_if #(.ADDR_W(AW)) ir_wr ();

  ir_capture_sequencer #(
    .IR_LENGTH      (IRL),
    .ADDR_W         (AW),
    .QUIET_SAMPLES  (QS),
    .QUIET_THRESH   (QT),
    .TIMEOUT_SAMPLES(TO),
    .PULSE_SAMPLES  (PS),
    .PULSE_AMP      (16'sh7FFF)
  ) dut (
    .audio_clk       (audio_clk),
    .rst_in_n        (rst_in_n),
    .audio_trigger   (audio_trigger),
    .start           (start),
    .abort           (abort),
    .delay_length    (delay_length),
    .audio_in        (audio_in),
    .impulse_out     (impulse_out),
    .ir_wr           (ir_wr),
    .impulse_recorded(impulse_recorded),
    .busy            (busy),
    .error           (error),
    .state_out       (state_out)
`ifdef IR_CAPTURE_PEAK_EN
    ,
    .peak_mag        (peak_mag),
    .peak_addr       (peak_addr)
`endif
  );

  always #5 audio_clk = ~audio_clk;

  typedef struct {
    logic [7:0] delay;
    sample_t    qv;     // sample driven while armed
    bit         alt;    // alternate the sign of qv every strobe
    bit         err;    // quiet timeout expected
    bit         chg;    // change delay_length to 200 mid-skip
    int         off;    // expected strobes from pulse start to first write
  } vec_t;

  vec_t    vecs[9];
  int      total = 0;
  int      bad   = 0;
  int      sn;
  int      pulse_cnt;
  int      wr_count;
  int      exp_addr;
  int      first_wr_sn;
  sample_t last_drv;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge audio_clk) begin
    if (ir_wr.ir_write_enable === 1'b1) begin
      check("wr_addr", int'(ir_wr.ir_write_addr), exp_addr);
      check("wr_data", int'(ir_wr.ir_write_data), int'(last_drv));
      if (wr_count == 0) first_wr_sn = sn;
      wr_count++;
      exp_addr++;
    end
  end

  task automatic strobe(input sample_t v);
    @(negedge audio_clk);
    if (impulse_out == 16'sh7FFF) pulse_cnt++;
    sn++;
    audio_in      = v;
    last_drv      = v;
    audio_trigger = 1'b1;
    @(negedge audio_clk);
    audio_trigger = 1'b0;
    @(negedge audio_clk);
  endtask

  // k is the record index: a saturating peak at 3 and an equal later peak at 7.
  function automatic sample_t rec_val(input int k);
    sample_t r;
    if (k == 3) r = 16'sh8000;
    else if (k == 7) r = 16'sh7FFF;
    else r = sample_t'(k * 100 - 300);
    return r;
  endfunction

  task automatic begin_entry();
    sn          = 0;
    pulse_cnt   = 0;
    wr_count    = 0;
    exp_addr    = 0;
    first_wr_sn = -1;
  endtask

  task automatic pulse_start();
    @(negedge audio_clk);
    start = 1'b1;
    @(negedge audio_clk);
    start = 1'b0;
  endtask

  task automatic run_entry(input int n, input vec_t v);
    sample_t s;
    begin_entry();
    delay_length = v.delay;
    pulse_start();
    check($sformatf("v%0d arm_state", n), int'(state_out), 1);
    check($sformatf("v%0d arm_busy", n), int'(busy), 1);
    check($sformatf("v%0d arm_rec_clr", n), int'(impulse_recorded), 0);
    check($sformatf("v%0d arm_err_clr", n), int'(error), 0);
    if (v.err) begin
      for (int i = 1; i <= int'(TO); i++) begin
        s = (v.alt && (i % 2 == 0)) ? -v.qv : v.qv;
        strobe(s);
        if (i == int'(TO) - 1) check($sformatf("v%0d pre_timeout", n), int'(state_out), 1);
      end
      check($sformatf("v%0d err_state", n), int'(state_out), 6);
      check($sformatf("v%0d err_flag", n), int'(error), 1);
      check($sformatf("v%0d err_busy", n), int'(busy), 0);
      check($sformatf("v%0d err_rec", n), int'(impulse_recorded), 0);
      check($sformatf("v%0d err_writes", n), wr_count, 0);
      check($sformatf("v%0d err_pulses", n), pulse_cnt, 0);
    end else begin
      for (int i = 1; i <= int'(QS); i++) begin
        strobe(v.qv);
        if (i == int'(QS) - 1) check($sformatf("v%0d pre_quiet", n), int'(state_out), 1);
      end
      check($sformatf("v%0d pulse_state", n), int'(state_out), 2);
      for (int i = 0; i < v.off + int'(IRL) + 2; i++) begin
        strobe(rec_val(i - v.off));
        if (v.chg && i == 5) delay_length = 8'd200;
      end
      check($sformatf("v%0d pulse_len", n), pulse_cnt, int'(PS));
      check($sformatf("v%0d first_wr", n), first_wr_sn, int'(QS) + 1 + v.off);
      check($sformatf("v%0d wr_count", n), wr_count, int'(IRL));
      check($sformatf("v%0d done_state", n), int'(state_out), 5);
      check($sformatf("v%0d done_rec", n), int'(impulse_recorded), 1);
      check($sformatf("v%0d done_busy", n), int'(busy), 0);
      check($sformatf("v%0d done_imp", n), int'(impulse_out), 0);
`ifdef IR_CAPTURE_PEAK_EN
      check($sformatf("v%0d peak_mag", n), int'(peak_mag), 32767);
      check($sformatf("v%0d peak_addr", n), int'(peak_addr), 3);
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd10, 16'sd0,     1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{8'd10, 16'sd512,   1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{8'd4,  16'sd511,   1'b0, 1'b0, 1'b0, 4};
    vecs[3] = '{8'd2,  -16'sd511,  1'b0, 1'b0, 1'b0, 4};
    vecs[4] = '{8'd0,  16'sd0,     1'b0, 1'b0, 1'b0, 4};
    vecs[5] = '{8'd10, 16'sh8000,  1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{8'd10, -16'sd32767, 1'b0, 1'b1, 1'b0, 0};
    vecs[7] = '{8'd10, 16'sd1000,  1'b1, 1'b1, 1'b0, 0};
    vecs[8] = '{8'd10, 16'sd0,     1'b0, 1'b0, 1'b1, 10};

    rst_in_n      = 1'b0;
    audio_trigger = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    delay_length  = 8'd0;
    audio_in      = '0;
    last_drv      = '0;
    begin_entry();
    repeat (3) @(negedge audio_clk);
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_error", int'(error), 0);
    check("rst_rec", int'(impulse_recorded), 0);
    check("rst_imp", int'(impulse_out), 0);
    check("rst_wren", int'(ir_wr.ir_write_enable), 0);
    check("rst_addr", int'(ir_wr.ir_write_addr), 0);
    rst_in_n = 1'b1;
    @(negedge audio_clk);

    for (int n = 0; n < 9; n++) run_entry(n, vecs[n]);

    // Loud burst restarts the quiet run, then abort mid-record.
    begin_entry();
    delay_length = 8'd6;
    pulse_start();
    for (int i = 1; i <= 10; i++) strobe((i == 5) ? 16'sd1000 : 16'sd0);
    check("burst_still_arm", int'(state_out), 1);
    strobe(16'sd0);
    check("burst_pulse", int'(state_out), 2);
    for (int i = 0; i < 40 && wr_count < 5; i++) strobe(rec_val(i - 6));
    check("abort_pre_writes", wr_count, 5);
    check("abort_pre_state", int'(state_out), 4);
    @(negedge audio_clk);
    abort = 1'b1;
    @(negedge audio_clk);
    abort = 1'b0;
    check("abort_state", int'(state_out), 0);
    check("abort_imp", int'(impulse_out), 0);
    check("abort_rec", int'(impulse_recorded), 0);
    check("abort_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) strobe(16'sd0);
    check("abort_no_writes", wr_count, 5);
    check("abort_stays_idle", int'(state_out), 0);

    // Start and abort together in IDLE: abort wins.
    @(negedge audio_clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge audio_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_state", int'(state_out), 0);
    @(negedge audio_clk);
    check("start_abort_hold", int'(state_out), 0);

    // Fresh capture, then abort from DONE clears the recorded flag.
    run_entry(9, vecs[0]);
    @(negedge audio_clk);
    abort = 1'b1;
    @(negedge audio_clk);
    abort = 1'b0;
    check("done_abort_rec", int'(impulse_recorded), 0);
    check("done_abort_state", int'(state_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_capture_sequencer.md
Name: ir_capture_sequencer

Overview:
- Controller that runs one impulse-response measurement end to end: waits for a quiet room, fires a test impulse toward the speaker path, skips the acoustic delay, then writes IR_LENGTH mic samples into the IR buffer.
- Sits between the processed mic stream (24 kHz strobed) and the IR buffer write port.
- Owns the "impulse recorded" flag that enables the convolution engine.

Parameters:
- IR_LENGTH, 3000: number of samples written to the IR buffer.
- ADDR_W, 12: IR buffer address width; must satisfy 2**ADDR_W >= IR_LENGTH.
- QUIET_SAMPLES, 2400: consecutive quiet samples required before the pulse fires (100 ms).
- QUIET_THRESH, 512: magnitude below which a sample counts as quiet.
- TIMEOUT_SAMPLES, 48000: maximum samples spent in ARM before error.
- PULSE_SAMPLES, 4: length of the test impulse, in samples.
- PULSE_AMP, 16'sh7FFF: amplitude of the test impulse.

Ports:
- audio_clk  in  1  system audio clock, 98.3 MHz.
- rst_in_n  in  1  reset, asynchronous, active-low.
- audio_trigger  in  1  single-cycle sample strobe, 24 kHz.
- start  in  1  level request; internally edge-detected on its rising edge.
- abort  in  1  level; forces return to IDLE.
- delay_length  in  8  acoustic delay in samples; skipped between pulse start and record start.
- audio_in  in  16 signed  processed mic sample; valid when audio_trigger is high.
- impulse_out  out  16 signed  test-impulse drive, muxed to the PDM path by the top level.
- ir_write_addr  out  ADDR_W  IR buffer write address.
- ir_write_data  out  16 signed  IR buffer write data.
- ir_write_enable  out  1  single-cycle write strobe.
- impulse_recorded  out  1  high once a full capture has completed.
- busy  out  1  high in ARM, PULSE, SKIP and RECORD.
- error  out  1  high in ERROR (quiet timeout).
- state_out  out  3  current state encoding, for the seven-segment display.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Timing:
  - Every state action advances only on audio_trigger; counters are sample counts.
  - Outputs are registered, with one audio_clk of latency after the triggering strobe.
- IDLE:
  - On a start rising edge: go to ARM, clear impulse_recorded and the quiet counter, clear the timeout counter.
- ARM:
  - Per strobe, compute |audio_in| (saturating: -32768 gives 32767).
  - If |audio_in| < QUIET_THRESH, increment the quiet counter; otherwise reset it to 0.
  - When the quiet counter reaches QUIET_SAMPLES, go to PULSE.
  - The timeout counter increments every strobe. When it reaches TIMEOUT_SAMPLES, go to ERROR.
- PULSE:
  - impulse_out = PULSE_AMP for PULSE_SAMPLES strobes, then 0.
  - A skip counter starts at the first pulse strobe.
  - Go to SKIP after PULSE_SAMPLES strobes.
- SKIP:
  - Continue counting until skip count == delay_length, then go to RECORD.
  - delay_length is sampled at PULSE entry; later changes are ignored.
  - If delay_length < PULSE_SAMPLES, go to RECORD straight after the pulse; recording never overlaps the pulse.
- RECORD:
  - Per strobe, the next cycle drives ir_write_enable=1, ir_write_data=audio_in, and ir_write_addr = index, where index runs 0..IR_LENGTH-1.
  - After the write at index IR_LENGTH-1, go to DONE.
- DONE:
  - impulse_recorded=1 and held.
  - A new start edge goes to ARM and clears impulse_recorded; the buffer is overwritten from 0.
- ERROR:
  - error=1; impulse_recorded stays 0.
  - A new start edge goes to ARM with error cleared.
- abort:
  - Has priority over start and all transitions: next cycle the state is IDLE, impulse_out=0, no write strobe, impulse_recorded=0.
  - Abort mid-RECORD leaves a partial buffer; impulse_recorded stays 0.
- start while busy: ignored.
- Simultaneous start edge and abort: abort wins.
- Strobe spacing: two strobes are never closer than 2 cycles; the block need not handle back-to-back strobes.
- State encoding: IDLE=0, ARM=1, PULSE=2, SKIP=3, RECORD=4, DONE=5, ERROR=6.

Optional Feature:
- Macro: IR_CAPTURE_PEAK_EN.
- When defined:
  - Adds output peak_mag (16) and output peak_addr (ADDR_W).
  - These track the maximum |audio_in| and its index during RECORD.
  - Both are cleared on ARM entry; on a tie the first occurrence is kept.
  - Both are valid when impulse_recorded=1.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package ir_capture_pkg contains:
  - state enum ir_cap_state_t (3-bit);
  - typedef sample_t (logic signed [15:0]);
  - a saturating abs function;
  - the default constants.
- Sub-module quiet_detector contains the abs, threshold compare and consecutive quiet counter.
  - Ports: audio_clk, rst_in_n, clear, strobe, sample, quiet_done.
  - Parameters: QUIET_SAMPLES, QUIET_THRESH.

Test Plan:
- Silent input (0), delay_length=10, start → exactly 4 strobes of impulse_out=32767 after 2400 quiet strobes; first write at addr 0 on pulse-start strobe +10; 3000 writes; impulse_recorded=1 after addr 2999; busy=0.
- Input alternates ±1000 (loud), start → error=1 at strobe 48000, state_out=6, no writes; then silent input and start → capture completes normally.
- Loud burst of 1000 at quiet strobe 2000 → quiet counter restarts; pulse fires 2400 strobes after the burst ends.
- abort asserted at RECORD index 1500 → state_out=0 next cycle, ir_write_enable never asserted again, impulse_recorded=0.
- start and abort rising on the same cycle in IDLE → remains IDLE; delay_length changed from 10 to 200 during SKIP → recording still starts at offset 10.
- audio_in=-32768 during RECORD with IR_CAPTURE_PEAK_EN defined → peak_mag=32767 at that index; a later equal peak does not update peak_addr.
